// File: rtl/trap_controller_pkg.sv
// Shared trap definitions: cause codes, privilege encodings, FSM states and
// the exception-request bundle used by the trap controller and its encoder.
package trap_controller_pkg;

    // Synchronous exception cause codes (mcause, interrupt bit clear).
    localparam logic [3:0] CAUSE_MISALIGN_FETCH = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] CAUSE_MISALIGN_LOAD  = 4'd4;
    localparam logic [3:0] CAUSE_MISALIGN_STORE = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_U        = 4'd8;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

    // Privilege levels.
    localparam logic [1:0] UMODE = 2'b00;
    localparam logic [1:0] MMODE = 2'b11;

    // Trap sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_RET   = 2'd2,
        ST_REDIR = 2'd3
    } trap_state_e;

    // Source of the trap value written to mtval.
    typedef enum logic [1:0] {
        TVAL_ZERO = 2'd0,
        TVAL_INST = 2'd1,
        TVAL_ADDR = 2'd2
    } tval_sel_e;

    // Exception requests raised by the execute stage.
    typedef struct packed {
        logic misalign_fetch;
        logic illegal_inst;
        logic ebreak_inst;
        logic misalign_load;
        logic misalign_store;
        logic ecall_inst;
    } trap_req_t;

    // Environment-call cause depends on the privilege the ecall came from.
    function automatic logic [3:0] ecall_cause(input logic [1:0] priv);
        return (priv == MMODE) ? CAUSE_ECALL_M : CAUSE_ECALL_U;
    endfunction

endpackage

// File: rtl/trap_controller_cause_encoder.sv
// Priority encoder: turns the raw exception requests plus MRET into a single
// trap decision, its cause code and where its mtval comes from.
module trap_controller_cause_encoder
    import trap_controller_pkg::*;
(
    input  trap_req_t   req_i,
    input  logic [1:0]  priv_mode_i,
    input  logic        mret_i,
    output logic        take_exc_o,
    output logic        take_ret_o,
    output logic [3:0]  cause_o,
    output tval_sel_e   tval_sel_o
);

    // An MRET outside M-mode is reported as an illegal instruction.
    logic mret_illegal;
    assign mret_illegal = mret_i && (priv_mode_i != MMODE);

    // Highest-priority request wins; a legal MRET only if nothing else fires.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        take_exc_o = 1'b1;
        take_ret_o = 1'b0;
        cause_o    = CAUSE_MISALIGN_FETCH;
        tval_sel_o = TVAL_ZERO;
        if (req_i.misalign_fetch) begin
            cause_o    = CAUSE_MISALIGN_FETCH;
            tval_sel_o = TVAL_ADDR;
        end else if (req_i.illegal_inst || mret_illegal) begin
            cause_o    = CAUSE_ILLEGAL;
            tval_sel_o = TVAL_INST;
        end else if (req_i.ebreak_inst) begin
            cause_o    = CAUSE_BREAKPOINT;
        end else if (req_i.misalign_load) begin
            cause_o    = CAUSE_MISALIGN_LOAD;
            tval_sel_o = TVAL_ADDR;
        end else if (req_i.misalign_store) begin
            cause_o    = CAUSE_MISALIGN_STORE;
            tval_sel_o = TVAL_ADDR;
        end else if (req_i.ecall_inst) begin
            cause_o    = ecall_cause(priv_mode_i);
        end else begin
            take_exc_o = 1'b0;
            take_ret_o = mret_i;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// M-mode trap initiator: detects exceptions and MRET in execute, pulses the
// CSR file's trap-entry/return inputs, then redirects the PC. The pipeline is
// flushed in the detect cycle and stalled for the three-cycle sequence.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               reset_x,
    input  logic               inst_valid,
    input  logic [XLEN-1:0]    pc_in,
    input  logic [XLEN-1:0]    inst_in,
    input  logic [XLEN-1:0]    bad_addr,
    input  logic               misalign_fetch,
    input  logic               illegal_inst,
    input  logic               ebreak_inst,
    input  logic               misalign_load,
    input  logic               misalign_store,
    input  logic               ecall_inst,
    input  logic               mret_inst,
    input  logic [1:0]         priv_mode,
    input  logic [XLEN-1:0]    mtvec_in,
    input  logic [XLEN-1:0]    mepc_in,
    output logic               exception_o,
    output logic               mret_o,
    output logic [CAUSE_W-1:0] mcause_out,
    output logic [XLEN-1:0]    mepc_out,
    output logic [XLEN-1:0]    mtval_out,
    output logic [1:0]         priv_out,
    output logic               flush,
    output logic               stall,
    output logic               pc_redirect,
    output logic [XLEN-1:0]    trap_pc
);

    trap_state_e         state_q;
    logic                exception_q;
    logic                mret_q;
    logic                stall_q;
    logic                redirect_q;
    logic [CAUSE_W-1:0]  mcause_q;
    logic [XLEN-1:0]     mepc_q;
    logic [XLEN-1:0]     mtval_q;
    logic [1:0]          priv_q;
    logic [XLEN-1:0]     trap_pc_q;

    trap_req_t           req;
    logic                take_exc;
    logic                take_ret;
    logic [3:0]          cause;
    tval_sel_e           tval_sel;
    logic [XLEN-1:0]     tval_d;
    logic                start_exc;
    logic                start_ret;

    assign req = '{misalign_fetch: misalign_fetch, illegal_inst: illegal_inst,
                   ebreak_inst: ebreak_inst, misalign_load: misalign_load,
                   misalign_store: misalign_store, ecall_inst: ecall_inst};

    trap_controller_cause_encoder u_cause_encoder (
        .req_i       (req),
        .priv_mode_i (priv_mode),
        .mret_i      (mret_inst),
        .take_exc_o  (take_exc),
        .take_ret_o  (take_ret),
        .cause_o     (cause),
        .tval_sel_o  (tval_sel)
    );

    // Requests are only honoured in IDLE; elsewhere the pipeline is frozen.
    assign start_exc = (state_q == ST_IDLE) && inst_valid && take_exc;
    assign start_ret = (state_q == ST_IDLE) && inst_valid && take_ret;

    // Kill the detecting instruction's writeback in the same cycle.
    assign flush = start_exc || start_ret;

    // Trap value chosen by the encoder.
    always_comb begin
        tval_d = '0;
        case (tval_sel)
            TVAL_INST: tval_d = inst_in;
            TVAL_ADDR: tval_d = bad_addr;
            default:   tval_d = '0;
        endcase
    end

    // Trap sequencer with registered pulses, stall and latched CSR fields.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q     <= ST_IDLE;
            exception_q <= 1'b0;
            mret_q      <= 1'b0;
            stall_q     <= 1'b0;
            redirect_q  <= 1'b0;
            mcause_q    <= '0;
            mepc_q      <= '0;
            mtval_q     <= '0;
            priv_q      <= '0;
            trap_pc_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            exception_q <= 1'b0;
            mret_q      <= 1'b0;
            redirect_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_exc || start_ret) begin
                        state_q     <= start_exc ? ST_ENTER : ST_RET;
                        exception_q <= start_exc;
                        mret_q      <= start_ret;
                        stall_q     <= 1'b1;
                        mcause_q    <= CAUSE_W'(cause);
                        mtval_q     <= tval_d;
                        mepc_q      <= pc_in;
                        priv_q      <= priv_mode;
                    end
                end
                ST_ENTER: begin
                    // Direct mode only: low two mtvec bits are mode, not address.
                    state_q    <= ST_REDIR;
                    redirect_q <= 1'b1;
                    trap_pc_q  <= mtvec_in & ~XLEN'(3);
                end
                ST_RET: begin
                    state_q    <= ST_REDIR;
                    redirect_q <= 1'b1;
                    trap_pc_q  <= mepc_in;
                end
                default: begin
                    state_q <= ST_IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign exception_o = exception_q;
    assign mret_o      = mret_q;
    assign stall       = stall_q;
    assign pc_redirect = redirect_q;
    assign mcause_out  = mcause_q;
    assign mepc_out    = mepc_q;
    assign mtval_out   = mtval_q;
    assign priv_out    = priv_q;
    assign trap_pc     = trap_pc_q;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: each trap pushes the expected
// per-cycle outputs (T..T+3) and a negedge monitor pops and compares them.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        inst_valid;
    logic [31:0] pc_in, inst_in, bad_addr, mtvec_in, mepc_in;
    logic        misalign_fetch, illegal_inst, ebreak_inst;
    logic        misalign_load, misalign_store, ecall_inst, mret_inst;
    logic [1:0]  priv_mode;
    logic        exception_o, mret_o, flush, stall, pc_redirect;
    logic [3:0]  mcause_out;
    logic [31:0] mepc_out, mtval_out, trap_pc;
    logic [1:0]  priv_out;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic        flush, exc, mret, stall, redir;
        logic [3:0]  cause;
        logic [31:0] epc, tval, tpc;
        logic [1:0]  priv;
    } exp_t;

    exp_t sb[$];

    // Model of the latched CSR-facing fields.
    logic [3:0]  m_cause;
    logic [31:0] m_epc, m_tval, m_tpc;
    logic [1:0]  m_priv;

    trap_controller #(.XLEN(32), .CAUSE_W(4)) dut (
        .clk            (clk),
        .reset_x        (reset_x),
        .inst_valid     (inst_valid),
        .pc_in          (pc_in),
        .inst_in        (inst_in),
        .bad_addr       (bad_addr),
        .misalign_fetch (misalign_fetch),
        .illegal_inst   (illegal_inst),
        .ebreak_inst    (ebreak_inst),
        .misalign_load  (misalign_load),
        .misalign_store (misalign_store),
        .ecall_inst     (ecall_inst),
        .mret_inst      (mret_inst),
        .priv_mode      (priv_mode),
        .mtvec_in       (mtvec_in),
        .mepc_in        (mepc_in),
        .exception_o    (exception_o),
        .mret_o         (mret_o),
        .mcause_out     (mcause_out),
        .mepc_out       (mepc_out),
        .mtval_out      (mtval_out),
        .priv_out       (priv_out),
        .flush          (flush),
        .stall          (stall),
        .pc_redirect    (pc_redirect),
        .trap_pc        (trap_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop one expected cycle per negedge while the scoreboard holds entries.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".flush"},  32'(flush),       32'(e.flush));
            check({e.name, ".exc"},    32'(exception_o), 32'(e.exc));
            check({e.name, ".mret"},   32'(mret_o),      32'(e.mret));
            check({e.name, ".stall"},  32'(stall),       32'(e.stall));
            check({e.name, ".redir"},  32'(pc_redirect), 32'(e.redir));
            check({e.name, ".mcause"}, 32'(mcause_out),  32'(e.cause));
            check({e.name, ".mepc"},   mepc_out,         e.epc);
            check({e.name, ".mtval"},  mtval_out,        e.tval);
            check({e.name, ".priv"},   32'(priv_out),    32'(e.priv));
            check({e.name, ".trappc"}, trap_pc,          e.tpc);
        end
    end

    task automatic drive_req(input logic [6:0] req);
        {misalign_fetch, illegal_inst, ebreak_inst, misalign_load,
         misalign_store, ecall_inst, mret_inst} = req;
    endtask

    function automatic exp_t mk(input string name, input logic fl, input logic ex,
                                input logic mr, input logic st, input logic rd);
        exp_t e;
        e.name = name; e.flush = fl; e.exc = ex; e.mret = mr; e.stall = st; e.redir = rd;
        e.cause = m_cause; e.epc = m_epc; e.tval = m_tval; e.tpc = m_tpc; e.priv = m_priv;
        return e;
    endfunction

    // req = {fetch, illegal, ebreak, load, store, ecall, mret}.
    // hold keeps the request asserted through the stall to show it is ignored.
    task automatic run(input string name, input logic [6:0] req, input logic [1:0] priv,
                       input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] mtvec, input logic [31:0] mepc, input bit is_ret,
                       input logic [3:0] cause, input logic [31:0] tval, input logic [31:0] tpc,
                       input bit hold);
        @(posedge clk); #1;
        drive_req(req);
        priv_mode = priv; pc_in = pc; inst_in = inst; bad_addr = addr;
        mtvec_in = mtvec; mepc_in = mepc; inst_valid = 1'b1;
        sb.push_back(mk({name, "@T"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        m_cause = cause; m_epc = pc; m_tval = tval; m_priv = priv;
        sb.push_back(mk({name, "@T1"}, 1'b0, !is_ret, is_ret, 1'b1, 1'b0));
        m_tpc = tpc;
        sb.push_back(mk({name, "@T2"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        sb.push_back(mk({name, "@T3"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        if (!hold) begin inst_valid = 1'b0; drive_req('0); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        inst_valid = 1'b0; drive_req('0);
    endtask

    initial begin
        reset_x = 1'b0; inst_valid = 1'b0; drive_req('0);
        priv_mode = 2'b11; pc_in = '0; inst_in = '0; bad_addr = '0;
        mtvec_in = '0; mepc_in = '0;
        m_cause = '0; m_epc = '0; m_tval = '0; m_tpc = '0; m_priv = '0;
        #12;
        check("rst.exc",   32'(exception_o), 32'd0);
        check("rst.mret",  32'(mret_o),      32'd0);
        check("rst.stall", 32'(stall),       32'd0);
        check("rst.redir", 32'(pc_redirect), 32'd0);
        check("rst.trappc", trap_pc, 32'd0);
        check("rst.mepc",   mepc_out, 32'd0);
        check("rst.mtval",  mtval_out, 32'd0);
        @(negedge clk); reset_x = 1'b1;

        run("illegal", 7'b0100000, 2'b11, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h200, 32'h0,
            1'b0, 4'd2, 32'hFFFF_FFFF, 32'h200, 1'b0);
        run("ecall_u", 7'b0000010, 2'b00, 32'h140, 32'h0000_0073, 32'hDEAD, 32'h200, 32'h0,
            1'b0, 4'd8, 32'h0, 32'h200, 1'b0);
        run("ecall_m", 7'b0000010, 2'b11, 32'h144, 32'h0000_0073, 32'h0, 32'h300, 32'h0,
            1'b0, 4'd11, 32'h0, 32'h300, 1'b0);
        run("mret_m",  7'b0000001, 2'b11, 32'h208, 32'h3020_0073, 32'h0, 32'h200, 32'h104,
            1'b1, 4'd0, 32'h0, 32'h104, 1'b0);
        run("mret_u",  7'b0000001, 2'b00, 32'h20C, 32'h3020_0073, 32'h0, 32'h400, 32'h104,
            1'b0, 4'd2, 32'h3020_0073, 32'h400, 1'b0);
        run("prio",    7'b1100010, 2'b11, 32'h110, 32'h1234_5678, 32'h3, 32'h201, 32'h0,
            1'b0, 4'd0, 32'h3, 32'h200, 1'b0);
        run("exc_mret", 7'b0010001, 2'b11, 32'h120, 32'h0010_0073, 32'h0, 32'h500, 32'h104,
            1'b0, 4'd3, 32'h0, 32'h500, 1'b0);
        run("ld_hold", 7'b0001000, 2'b11, 32'h130, 32'h0000_2003, 32'h1001, 32'h600, 32'h0,
            1'b0, 4'd4, 32'h1001, 32'h600, 1'b1);
        run("st",      7'b0000100, 2'b00, 32'h134, 32'h0000_2023, 32'h2002, 32'h700, 32'h0,
            1'b0, 4'd6, 32'h2002, 32'h700, 1'b0);

        // Asynchronous reset while in ENTER.
        @(posedge clk); #1;
        drive_req(7'b0100000); priv_mode = 2'b11; pc_in = 32'h180;
        inst_in = 32'hABCD_0000; mtvec_in = 32'h800; inst_valid = 1'b1;
        sb.push_back(mk("rstmid@T", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        inst_valid = 1'b0; drive_req('0);
        check("rstmid.enter", 32'(exception_o), 32'd1);
        #1 reset_x = 1'b0;
        #1;
        check("rstmid.exc",    32'(exception_o), 32'd0);
        check("rstmid.stall",  32'(stall),       32'd0);
        check("rstmid.mcause", 32'(mcause_out),  32'd0);
        check("rstmid.mepc",   mepc_out,         32'd0);
        check("rstmid.mtval",  mtval_out,        32'd0);
        check("rstmid.flush",  32'(flush),       32'd0);
        m_cause = '0; m_epc = '0; m_tval = '0; m_tpc = '0; m_priv = '0;
        @(negedge clk); reset_x = 1'b1;

        run("post_rst", 7'b0100000, 2'b11, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h200, 32'h0,
            1'b0, 4'd2, 32'hFFFF_FFFF, 32'h200, 1'b0);

        repeat (3) @(posedge clk);
        check("sb.drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
